// File: rtl/lm96570_fire_scheduler.sv
// LM96570 fire scheduler.
// This block controls the order of pulser configuration and firing. It asks
// the serial config writer to reconfigure the pulser, then waits for the
// writer to finish and for a settle time. After that it fires bursts of
// TX_EN pulses on a fixed pulse-repetition interval. Reconfiguration never
// overlaps a burst, because a pending request is served only at a frame
// boundary or from IDLE.
module lm96570_fire_scheduler #(
  parameter int unsigned TX_WIDTH      = 4,
  parameter int unsigned PRI_CYCLES    = 200,
  parameter int unsigned BURST_LEN     = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned CFG_TIMEOUT   = 4096,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             EN,
  input  logic             cfg_req,
  input  logic             cfg_done,
  output logic             cfg_start,
  output logic             TX_EN,
  output logic [CNT_W-1:0] fire_idx,
  output logic             frame_done,
  output logic             busy,
  output logic             err_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    CFG_WAIT,
    SETTLE,
    FIRE,
    GAP
  } state_e;

  localparam int unsigned GAP_CYCLES = PRI_CYCLES - TX_WIDTH;

  // A single shared timer covers the longest phase in any state.
  localparam int unsigned MAX_A   = (CFG_TIMEOUT > SETTLE_CYCLES) ? CFG_TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned MAX_B   = (TX_WIDTH > GAP_CYCLES) ? TX_WIDTH : GAP_CYCLES;
  localparam int unsigned TMR_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] CFG_LAST    = TMR_W'(CFG_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TX_LAST     = TMR_W'(TX_WIDTH - 1);
  localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDX_LAST    = CNT_W'(BURST_LEN - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic               cfg_pend_q, cfg_pend_d;
  logic               err_q, err_d;
  logic               cfg_start_q, cfg_start_d;
  logic               tx_en_q, tx_en_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q, busy_d;
  logic               cfg_accept;

  // Next-state logic. All outputs are taken from the next state, so each
  // output changes on the same edge as the state transition that causes it.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. This
    // keeps all paths assigned, so no latch is inferred.
    state_d     = state_q;
    tmr_d       = tmr_q + TMR_W'(1);
    idx_d       = idx_q;
    cfg_valid_d = cfg_valid_q;
    err_d       = err_q;
    cfg_accept  = 1'b0;

    case (state_q)
      IDLE: begin
        tmr_d = '0;
        // A pending request or a missing config takes priority over firing.
        // After a timeout, automatic configuration stays off until a new
        // request arrives.
        if (cfg_pend_q || (EN && !cfg_valid_q && !err_q)) begin
          state_d = CFG_WAIT;
        end else if (EN && cfg_valid_q) begin
          state_d = FIRE;
        end
      end

      CFG_WAIT: begin
        // If cfg_done arrives on the last allowed cycle, it wins over the timeout.
        if (cfg_done) begin
          cfg_accept  = 1'b1;
          cfg_valid_d = 1'b1;
          err_d       = 1'b0;
          state_d     = SETTLE;
          tmr_d       = '0;
        end else if (tmr_q == CFG_LAST) begin
          err_d       = 1'b1;
          cfg_valid_d = 1'b0;
          state_d     = IDLE;
          tmr_d       = '0;
        end
      end

      SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      end

      FIRE: begin
        // EN is not checked here, so a pulse that has started always runs to full width.
        if (tmr_q == TX_LAST) begin
          state_d = GAP;
          tmr_d   = '0;
        end
      end

      GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (cfg_pend_q) begin
              state_d = CFG_WAIT;
            end else if (EN) begin
              state_d = FIRE;
            end else begin
              state_d = IDLE;
            end
          end else if (EN) begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = FIRE;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase

    // A request that arrives in the same cycle as the accepted cfg_done
    // stays pending.
    cfg_pend_d   = (cfg_pend_q && !cfg_accept) || cfg_req;

    cfg_start_d  = (state_d == CFG_WAIT) && (state_q != CFG_WAIT);
    tx_en_d      = (state_d == FIRE);
    busy_d       = (state_d != IDLE);
    // frame_done is computed one cycle ahead, so the registered pulse lines
    // up with the last GAP cycle of the frame.
    frame_done_d = (state_d == GAP) && (tmr_d == GAP_LAST) && (idx_d == IDX_LAST);
  end

  // State and registered outputs. The reset is synchronous.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples values from before the edge.
    if (RST) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      idx_q        <= '0;
      cfg_valid_q  <= 1'b0;
      cfg_pend_q   <= 1'b0;
      err_q        <= 1'b0;
      cfg_start_q  <= 1'b0;
      tx_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      idx_q        <= idx_d;
      cfg_valid_q  <= cfg_valid_d;
      cfg_pend_q   <= cfg_pend_d;
      err_q        <= err_d;
      cfg_start_q  <= cfg_start_d;
      tx_en_q      <= tx_en_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign cfg_start   = cfg_start_q;
  assign TX_EN       = tx_en_q;
  assign fire_idx    = idx_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_lm96570_fire_scheduler.sv
// Bench for lm96570_fire_scheduler.
// The stimulus process plans each scenario with plain cycle arithmetic from
// the pulser timing rules. It pushes the expected output events into a list
// sorted by time. A separate monitor turns DUT output edges into events,
// pops the expected list and compares the two.
module tb_lm96570_fire_scheduler;

  localparam int TX_WIDTH = 4;
  localparam int PRI      = 200;
  localparam int BURST    = 16;
  localparam int SETTLE   = 8;
  localparam int TMO      = 4096;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             RST = 1'b1;
  logic             EN = 1'b0;
  logic             cfg_req = 1'b0;
  logic             cfg_done = 1'b0;
  logic             cfg_start;
  logic             TX_EN;
  logic [CNT_W-1:0] fire_idx;
  logic             frame_done;
  logic             busy;
  logic             err_timeout;

  lm96570_fire_scheduler #(
    .TX_WIDTH(TX_WIDTH), .PRI_CYCLES(PRI), .BURST_LEN(BURST),
    .SETTLE_CYCLES(SETTLE), .CFG_TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .RST(RST), .EN(EN), .cfg_req(cfg_req), .cfg_done(cfg_done),
    .cfg_start(cfg_start), .TX_EN(TX_EN), .fire_idx(fire_idx),
    .frame_done(frame_done), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef enum int {EV_CFG_START, EV_TX_RISE, EV_TX_FALL, EV_FRAME_DONE,
                    EV_ERR_RISE, EV_ERR_FALL} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
    int  idx;
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string name, input longint got, input longint req);
    n_checks++;
    if (got == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
  endtask

  // Insert in time order. Events that share a cycle keep the order in which
  // they were pushed.
  task automatic push(input ev_e k, input int c, input int i);
    int pos = exp_q.size();
    while (pos > 0 && exp_q[pos-1].cyc > c) pos--;
    exp_q.insert(pos, '{kind: k, cyc: c, idx: i});
  endtask

  // Expected events for consecutive pulses k = first .. first+count-1 of a
  // train whose first rising edge is at cycle f.
  task automatic push_pulses(input int f, input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      push(EV_TX_RISE, f + k * PRI, k % BURST);
      push(EV_TX_FALL, f + k * PRI + TX_WIDTH, k % BURST);
      if (k % BURST == BURST - 1) push(EV_FRAME_DONE, f + (k + 1) * PRI - 1, BURST - 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return just after edge c. Inputs set after this are sampled at edge c+1.
  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic got_event(input ev_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got %s at cycle %0d idx %0d, required none",
               k.name(), cyc, fire_idx);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s_kind", e.kind.name()), k, e.kind);
      check($sformatf("%s_cycle", e.kind.name()), cyc, e.cyc);
      check($sformatf("%s_idx", e.kind.name()), fire_idx, e.idx);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic prev_tx = 1'b0;
  logic prev_err = 1'b0;
  always @(negedge clk) begin
    if (cfg_start === 1'b1)                 got_event(EV_CFG_START);
    if (TX_EN === 1'b1 && !prev_tx)         got_event(EV_TX_RISE);
    if (TX_EN === 1'b0 && prev_tx)          got_event(EV_TX_FALL);
    if (frame_done === 1'b1)                got_event(EV_FRAME_DONE);
    if (err_timeout === 1'b1 && !prev_err)  got_event(EV_ERR_RISE);
    if (err_timeout === 1'b0 && prev_err)   got_event(EV_ERR_FALL);
    prev_tx  = (TX_EN === 1'b1);
    prev_err = (err_timeout === 1'b1);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_start"}, cfg_start, 0);
    check({tag, "_tx_en"}, TX_EN, 0);
    check({tag, "_fire_idx"}, fire_idx, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  task automatic pulse_cfg_done(input int at, input logic with_req);
    wait_until(at - 1);
    cfg_done = 1'b1;
    cfg_req  = with_req;
    tick();
    cfg_done = 1'b0;
    cfg_req  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, d, f, p, c;

    // Reset state.
    repeat (3) tick();
    check_reset_outputs("reset");

    // Power-up: EN triggers the first config. The writer answers after 50 cycles.
    RST = 1'b0;
    EN  = 1'b1;
    s = cyc + 1;
    push(EV_CFG_START, s, 0);
    d = s + 50;
    pulse_cfg_done(d, 1'b0);
    check("cfg_wait_to_settle_busy", busy, 1);

    // Three frames back to back. A request mid-frame 3 is served at the frame boundary.
    f = d + SETTLE + 1;
    push_pulses(f, 0, 3 * BURST);
    p = $urandom_range(2, 13);
    c = f + (2 * BURST + p) * PRI + $urandom_range(0, PRI - 2);
    wait_until(c);
    check("mid_frame_idx", fire_idx, p);
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    s = f + 3 * BURST * PRI;
    push(EV_CFG_START, s, 0);
    d = s + $urandom_range(1, 300);
    pulse_cfg_done(d, 1'b0);

    // Firing resumes at index 0. EN drops inside the FIRE phase of pulse p.
    f = d + SETTLE + 1;
    p = $urandom_range(1, 14);
    push_pulses(f, 0, p + 1);
    wait_until(f + p * PRI + $urandom_range(0, TX_WIDTH - 1));
    EN = 1'b0;
    wait_until(f + (p + 1) * PRI);
    check("abort_fire_idx", fire_idx, 0);
    check("abort_busy", busy, 0);
    check("abort_tx_en", TX_EN, 0);

    // With a valid config, EN fires after 1 cycle. RST then hits while TX_EN is high.
    repeat (5) tick();
    EN = 1'b1;
    c = cyc;
    push(EV_TX_RISE, c + 1, 0);
    wait_until(c + 2);
    RST = 1'b1;
    push(EV_TX_FALL, c + 3, 0);
    tick();
    check_reset_outputs("rst_in_fire");

    // The reset cleared cfg_valid, so EN forces a fresh config. RST hits again in CFG_WAIT.
    RST = 1'b0;
    push(EV_CFG_START, c + 4, 0);
    wait_until(c + 4 + $urandom_range(5, 100));
    RST = 1'b1;
    tick();
    check_reset_outputs("rst_in_cfg");

    // The writer never answers. err_timeout rises and EN does not retry.
    RST = 1'b0;
    s = cyc + 1;
    push(EV_CFG_START, s, 0);
    push(EV_ERR_RISE, s + TMO, 0);
    wait_until(s + TMO + 300);
    check("timeout_err", err_timeout, 1);
    check("timeout_busy", busy, 0);
    check("timeout_tx_en", TX_EN, 0);

    // An explicit request retries. cfg_req arrives together with cfg_done,
    // so the request stays pending and one more config round follows.
    cfg_req = 1'b1;
    c = cyc;
    tick();
    cfg_req = 1'b0;
    s = c + 2;
    push(EV_CFG_START, s, 0);
    d = s + $urandom_range(1, 300);
    push(EV_ERR_FALL, d, 0);
    pulse_cfg_done(d, 1'b1);
    s = d + SETTLE + 1;
    push(EV_CFG_START, s, 0);
    d = s + $urandom_range(1, 300);
    pulse_cfg_done(d, 1'b0);
    f = d + SETTLE + 1;
    push_pulses(f, 0, 3);
    wait_until(f + 2 * PRI);
    EN = 1'b0;
    wait_until(f + 3 * PRI + 20);
    check("final_busy", busy, 0);
    check("final_err", err_timeout, 0);

    // Every expected event must have been seen by now.
    check("pending_events", exp_q.size(), 0);
    foreach (exp_q[i])
      $display("  missing %s at cycle %0d idx %0d", exp_q[i].kind.name(), exp_q[i].cyc, exp_q[i].idx);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
